// File: rtl/ysyx_25030081_lsu.sv
// ysyx_25030081_lsu: multi-cycle load/store unit on a valid/ready memory bus.
// One transaction in flight: IDLE -> REQ -> WAIT -> RESP -> IDLE. Illegal and
// misaligned accesses go straight from IDLE to RESP without touching the bus.
// Optional build macro LSU_MISALIGN_CHECK_EN: when defined, a half access with
// addr[0]=1 or a word access with addr[1:0]!=0 faults. When undefined, such
// accesses are forced to their natural alignment and proceed normally.
module ysyx_25030081_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_op,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_illegal;
  logic                  req_misalign;
  logic [1:0]            req_off;
  logic [3:0]            req_mask;
  logic [DATA_WIDTH-1:0] req_lane_wdata;
  logic [DATA_WIDTH-1:0] load_lane;
  logic [DATA_WIDTH-1:0] load_ext;

  // Decode an incoming request: legality, effective lane offset, strobes, store data.
  always_comb begin
    if (req_wen) req_illegal = req_op[2] || (req_op[1:0] == 2'b11);
    else         req_illegal = (req_op[1:0] == 2'b11) || (req_op == 3'b110);
    // Half and word offsets are snapped to natural alignment; with the fault
    // check enabled a misaligned access never reaches the bus anyway.
    case (req_op[1:0])
      2'b00:   req_off = req_addr[1:0];
      2'b01:   req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    req_misalign = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
    case (req_op[1:0])
      2'b00: begin
        req_mask       = 4'b0001 << req_off;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask       = 4'b0011 << req_off;
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        req_mask       = 4'b1111;
        req_lane_wdata = req_wdata;
      end
    endcase
    if (!req_wen) req_mask = 4'b0000;
  end

  // Shift the addressed lane down and extend it according to the load op.
  always_comb begin
    load_lane = mem_resp_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  load_ext = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b100:  load_ext = {24'h000000, load_lane[7:0]};
      3'b001:  load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b101:  load_ext = {16'h0000, load_lane[15:0]};
      default: load_ext = load_lane;
    endcase
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_d       = state_q;
    wen_d         = wen_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    op_d          = op_q;
    off_d         = off_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr[ADDR_WIDTH-1:2];
          wdata_d = req_lane_wdata;
          wmask_d = req_mask;
          op_d    = req_op;
          off_d   = req_off;
          rdata_d = '0;
          if (req_illegal || req_misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          err_d   = mem_resp_err;
          rdata_d = (wen_q || mem_resp_err) ? '0 : load_ext;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_wen    = wen_q;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = (state_q == REQ) ? wmask_q : 4'b0000;
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign resp_err   = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Scoreboard bench for ysyx_25030081_lsu: a driver issues requests and pushes
// expected bus requests and responses; a bus responder and a response monitor
// compare what the DUT presents against those queues.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_op;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  ysyx_25030081_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rword;
    logic        berr;
    int          rdly;
    int          pdly;
    bit          rst_mode;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rrdly;
    int          lat;
  } exp_t;

  bus_t bus_q[$];
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_acc_cyc = 0;
  int done_cnt = 0, exp_done = 0;
  int nreq = 0, exp_nreq = 0;
  bit in_wait = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: derives the bus request and the WBU result from the
  // access rules, queues them, then drives the request until accepted.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] op, input logic [31:0] rword, input logic berr,
                        input int rdly, input int pdly, input int rrdly, input bit rst_mode);
    int nb, off, v, tmo;
    bit legal, mis, fault, acc;
    logic [31:0] wd, rd, sh;
    logic [3:0] mk;
    bus_t b;
    exp_t e;
    nb    = 1 << int'(op[1:0]);
    legal = wen ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_CHECK_EN
    mis = legal && ((int'(addr[1:0]) % nb) != 0);
`else
    mis = 1'b0;
`endif
    fault = !legal || mis;
    off   = (int'(addr[1:0]) / nb) * nb;
    wd = 32'h0;
    mk = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
      mk[i]        = wen && (i >= off) && (i < off + nb);
    end
    sh = rword >> (8 * off);
    if (nb == 1) begin
      v = int'(sh[7:0]);
      if (!op[2] && v >= 128) v -= 256;
      rd = 32'(v);
    end else if (nb == 2) begin
      v = int'(sh[15:0]);
      if (!op[2] && v >= 32768) v -= 65536;
      rd = 32'(v);
    end else begin
      rd = rword;
    end
    if (fault || wen || berr) rd = 32'h0;
    if (!fault) begin
      b.addr = {addr[31:2], 2'b00}; b.wen = wen; b.wdata = wd; b.mask = mk;
      b.rword = rword; b.berr = berr; b.rdly = rdly; b.pdly = pdly; b.rst_mode = rst_mode;
      bus_q.push_back(b);
      exp_nreq++;
    end
    if (!rst_mode) begin
      e.rdata = rd;
      e.err   = fault || berr;
      e.rrdly = rrdly;
      e.lat   = fault ? 1 : ((rdly == 0 && pdly == 0) ? 3 : 0);
      exp_q.push_back(e);
      exp_done++;
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_op = op;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; last_acc_cyc = cyc; end
    end
    chk("accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom_range(0, 1)); req_addr = $urandom;
    req_wdata = $urandom; req_op = 3'($urandom_range(0, 7));
    if (!rst_mode) begin
      tmo = 0;
      while (done_cnt != exp_done && tmo < 300) begin @(negedge clk); tmo++; end
      chk("txn_done", 32'(done_cnt), 32'(exp_done));
    end
  endtask

  // Bus responder: checks each request, applies ready/response delays, and
  // throws in stray response pulses whenever no response is legitimately due.
  initial begin : bus
    bus_t b;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && bus_q.size() != 0) begin
        b = bus_q.pop_front();
        mem_resp_valid = 1'b0;
        chk("mem_addr", mem_addr, b.addr);
        chk("mem_wen", 32'(mem_wen), 32'(b.wen));
        chk("mem_wmask", 32'(mem_wmask), 32'(b.mask));
        if (b.wen) chk("mem_wdata", mem_wdata, b.wdata);
        for (int i = 0; i < b.rdly; i++) begin
          mem_req_ready  = 1'b0;
          mem_resp_valid = ($urandom_range(0, 3) == 0);
          mem_resp_rdata = $urandom;
          mem_resp_err   = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
          chk("req_hold_addr", mem_addr, b.addr);
          chk("req_hold_mask", 32'(mem_wmask), 32'(b.mask));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("req_single", 32'(mem_req_valid), 32'd0);
        if (b.rst_mode) begin
          in_wait = 1'b1;
          while (!rst) @(negedge clk);
          while (rst) @(negedge clk);
          mem_resp_rdata = $urandom; mem_resp_err = 1'b0; mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0;
          in_wait = 1'b0;
        end else begin
          repeat (b.pdly) @(negedge clk);
          mem_resp_rdata = b.rword; mem_resp_err = b.berr; mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_rdata = $urandom;
        end
      end else begin
        mem_resp_valid = ($urandom_range(0, 5) == 0);
        mem_resp_rdata = $urandom;
        mem_resp_err   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: pops the expected result when resp_valid appears and
  // checks it every cycle until the WBU side accepts it.
  initial begin : mon
    exp_t e;
    int rrw;
    bit active, handshook, prev_mrv;
    active = 1'b0; handshook = 1'b0; prev_mrv = 1'b0; rrw = 0; resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !prev_mrv) nreq++;
      prev_mrv = mem_req_valid;
      if (handshook) begin
        handshook  = 1'b0;
        resp_ready = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        done_cnt++;
      end else if (resp_valid) begin
        if (!active && exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
          resp_ready = 1'b1;
        end else begin
          if (!active) begin
            e = exp_q.pop_front();
            active = 1'b1;
            rrw = e.rrdly;
            if (e.lat > 0) chk("latency", 32'(cyc - last_acc_cyc), 32'(e.lat));
          end
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("req_ready_resp", 32'(req_ready), 32'd0);
          if (rrw == 0) begin
            resp_ready = 1'b1; handshook = 1'b1; active = 1'b0;
          end else begin
            rrw--; resp_ready = 1'b0;
          end
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int tmo;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_op = 3'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases
    do_txn(1'b0, 32'h8000_0003, $urandom, 3'b000, 32'h8A00_0000, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0003, $urandom, 3'b100, 32'h8A00_0000, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0002, 32'h0000_BEEF, 3'b001, $urandom, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0004, $urandom, 3'b010, 32'hCAFE_F00D, 1'b0, 4, 1, 2, 1'b0);
    do_txn(1'b0, 32'h8000_0002, $urandom, 3'b010, 32'h1234_5678, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0001, $urandom, 3'b101, 32'hF00D_9ABC, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0000, $urandom, 3'b011, $urandom, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b1, 32'h8000_0000, $urandom, 3'b100, $urandom, 1'b0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0008, $urandom, 3'b010, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), 32'h8000_0000 + 32'($urandom_range(0, 255)), $urandom,
             3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    // Reset while the bus response is outstanding
    do_txn(1'b0, 32'h8000_0010, $urandom, 3'b010, $urandom, 1'b0, 0, 2, 0, 1'b1);
    tmo = 0;
    while (!in_wait && tmo < 50) begin @(negedge clk); tmo++; end
    chk("reached_wait", 32'(in_wait), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    end
    tmo = 0;
    while (in_wait && tmo < 50) begin @(negedge clk); tmo++; end
    chk("stray_resp_done", 32'(in_wait), 32'd0);

    do_txn(1'b0, 32'h8000_0020, $urandom, 3'b001, 32'h8001_7FFF, 1'b0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("bus_req_count", 32'(nreq), 32'(exp_nreq));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
Name: ysyx_25030081_lsu

Overview:
Multi-cycle load/store unit that replaces the combinational pmem access path with a handshaked memory bus.
- Accepts one load/store request from EXU.
- Drives a word-aligned request (address, write data, byte mask) to the memory bus and waits for the response.
- Lane-shifts and sign/zero-extends load data, then hands the result to WBU over a valid/ready handshake.
- One outstanding transaction; no pipelining.

Parameters:
ADDR_WIDTH, 32, request and bus address width.
DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).

Ports:
clk  in  1  clock.
rst  in  1  async active-high reset.
req_valid  in  1  EXU request valid.
req_ready  out  1  LSU can accept a request.
req_wen  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned.
req_op  in  3  funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
mem_req_valid  out  1  bus request valid.
mem_req_ready  in  1  bus accepts the request.
mem_wen  out  1  bus write.
mem_addr  out  ADDR_WIDTH  req_addr with bits [1:0] cleared.
mem_wdata  out  DATA_WIDTH  lane-shifted store data.
mem_wmask  out  4  byte strobes; 0000 for loads.
mem_resp_valid  in  1  bus response valid, single-cycle pulse.
mem_resp_rdata  in  DATA_WIDTH  raw read word.
mem_resp_err  in  1  bus error.
resp_valid  out  1  result valid to WBU.
resp_ready  in  1  WBU accepts the result.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  access fault (misaligned, illegal op, or bus error).

Behaviour:
Reset values
- Async reset (rst = 1) forces state IDLE.
- All valid outputs are 0, mem_wmask = 0, resp_rdata = 0, resp_err = 0.
- An in-flight transaction is dropped; a bus response arriving after reset is ignored.

States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch wen/addr/wdata/op.
  - Legal access: go to REQ.
  - Illegal op (load op 011/110/111; store with op[2] = 1 or op = 011): go to RESP with err = 1; no bus access.
- REQ: mem_req_valid = 1; address, data and mask are held stable until mem_req_ready. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, capture the extended data and err = mem_resp_err, then go to RESP. A mem_resp_valid in any other state is ignored.
- RESP: resp_valid = 1 with data and err held stable until resp_ready, then go to IDLE. req_ready stays 0 in this cycle, so no back-to-back acceptance.

Latency
- Request accepted at cycle N gives mem_req_valid at N+1.
- With zero-wait bus ready and the response at N+2, resp_valid is at N+3.

Lane rules (off = addr[1:0])
- sb: mask = 0001 << off; wdata = {4{byte}}.
- sh: mask = 0011 << off; wdata = {2{half}}.
- sw: mask = 1111; wdata unchanged.
- Load byte = rdata >> (8*off); load half = rdata >> (8*off).
- Extension: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word unchanged.

Error data: resp_rdata = 0 whenever resp_err = 1.

Optional Feature:
Macro: LSU_MISALIGN_CHECK_EN.
- Defined: half access with addr[0] = 1, or word access with addr[1:0] != 0, goes IDLE to RESP with resp_err = 1; no bus request is issued.
- Undefined: no misalignment fault. Offset is forced to natural alignment: half uses off = {addr[1], 0}, word uses off = 0. The access proceeds normally.
- Illegal-op faults occur in both builds.

Test Plan:
1. lb at 0x80000003, bus returns 0x8A000000 with ready and response immediate -> resp_valid 3 cycles after acceptance, resp_rdata = 0xFFFFFF8A, resp_err = 0; lbu on the same access -> 0x0000008A.
2. sh at 0x80000002, wdata 0x0000BEEF -> mem_addr = 0x80000000, mem_wmask = 1100, mem_wdata = 0xBEEFBEEF; resp_rdata = 0.
3. lw at 0x80000004 with mem_req_ready held low 4 cycles and resp_ready held low 2 cycles -> mem_req_valid and mem_addr stable throughout, exactly one bus request, resp stable until accepted; req_ready = 0 throughout.
4. lw at 0x80000002 -> with LSU_MISALIGN_CHECK_EN: no mem_req_valid, resp_err = 1, resp_rdata = 0. Without it: mem_addr = 0x80000000, full word returned.
5. Load op 011 -> resp_err = 1 with no bus access. Load with mem_resp_err = 1 -> resp_err = 1, resp_rdata = 0.
6. Assert rst while in WAIT, then pulse mem_resp_valid -> state IDLE, all valid outputs 0, req_ready = 1, no resp_valid.
